pe_cfg_sequencer: RTL and testbench
===================================

Name: pe_cfg_sequencer

Overview:
- Accepts one configuration bundle per layer, with four stage words and a stage-enable mask.
- Runs the enabled PE-array stages strictly in order DATA -> WICP -> TMPC -> POST, using a start/done handshake per stage.
- Sits between the host config port (cfg_valid/cfg_busy) and the stage engines of the PE_ROW x PE_COL array.
- Reports sequence completion and the cycle count of the last run.

Parameters:
DATA_CWIDTH, 32, width of DATA-stage config word
WICP_CWIDTH, 32, width of WICP-stage config word
TMPC_CWIDTH, 32, width of TMPC-stage config word
POST_CWIDTH, 32, width of POST-stage config word
CNT_WIDTH, 32, width of run-cycle counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_valid  in  1  host offers config bundle
cfg_busy  out  1  high = bundle not accepted this cycle
cfg_mask  in  4  stage enable; bit0 DATA, bit1 WICP, bit2 TMPC, bit3 POST
cfg_data_data  in  DATA_CWIDTH  DATA-stage config word
cfg_wicp_data  in  WICP_CWIDTH  WICP-stage config word
cfg_tmpc_data  in  TMPC_CWIDTH  TMPC-stage config word
cfg_post_data  in  POST_CWIDTH  POST-stage config word
{data,wicp,tmpc,post}_start  out  1 each  one-cycle stage start pulse
{data,wicp,tmpc,post}_cfg  out  *_CWIDTH  latched stage config word
{data,wicp,tmpc,post}_done  in  1 each  one-cycle stage completion pulse
seq_done  out  1  one-cycle pulse at end of sequence
last_cycles  out  CNT_WIDTH  length in cycles of the last completed run

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. cfg_busy=0, all *_start=0, seq_done=0, all *_cfg=0, last_cycles=0. Reset mid-run aborts immediately and the pending bundle is dropped.
- All outputs are registered.
- FSM states: IDLE, DATA, WICP, TMPC, POST, DONE.
- Accept: a bundle is accepted at the edge where cfg_valid=1 and cfg_busy=0 (call this cycle T).
  - The four words and the mask are latched into *_cfg and held stable until the next acceptance.
- Transition after acceptance, taken at the edge ending cycle T:
  - The FSM moves to the lowest enabled stage and drives its *_start=1 in cycle T+1 only.
  - If mask=0, the FSM moves to DONE instead.
- Stage wait:
  - The stage's *_done is sampled only from the cycle after its start.
  - A done arriving in the same cycle as its start is ignored.
  - A done from any non-active stage is ignored.
  - When the active done=1, the FSM moves at the next edge to the next enabled stage (that stage's start pulses) or to DONE.
  - There is no gap cycle between stages.
- DONE: held for one cycle.
  - seq_done=1 and last_cycles updated in that cycle.
  - Then the FSM returns to IDLE.
- cfg_busy=1 whenever state != IDLE, in every cycle from T+1 through DONE inclusive.
- Cycle counter:
  - Cleared at acceptance.
  - Increments every cycle from T+1.
  - last_cycles = number of cycles T+1..DONE inclusive.
  - Wraps modulo 2^CNT_WIDTH.
- Throughput: the earliest next acceptance is the IDLE cycle after DONE.

Optional Feature:
- Macro CFG_PREFETCH_EN.
- Defined:
  - Adds a one-entry pending buffer; cfg_busy = buffer full.
  - A bundle may be accepted during a run; it is held in the buffer, and the active *_cfg stays unchanged.
  - At DONE with the buffer full, the FSM goes directly to the buffered bundle's first enabled stage (or DONE if its mask=0), skipping IDLE.
  - The buffered words move to *_cfg on that edge and the buffer empties.
  - The counter restarts on that edge.
- Undefined: behaviour exactly as in Behaviour above.

Decomposition:
- Package pe_seq_pkg holds:
  - state enum typedef (IDLE..DONE);
  - stage index constants (STG_DATA=0..STG_POST=3);
  - a next-enabled-stage function that takes current stage and mask.
- A single module is sufficient.
- The pending buffer goes in an optional sub-module pe_cfg_slot, instantiated only under CFG_PREFETCH_EN.

Test Plan:
- Reset mid-WICP: assert rst_n=0 for one edge during WICP -> next cycle state IDLE, cfg_busy=0, no start or seq_done pulses; a later done is ignored.
- Full sequence: mask=4'b1111, each done returned 3 cycles after its start -> starts at T+1, T+4, T+7, T+10; seq_done at T+13; last_cycles=13; cfg_busy low at T+14.
- Skip stages: mask=4'b1010, dones after 2 cycles -> only wicp_start (T+1) and post_start (T+3); seq_done T+5; data_start and tmpc_start never pulse.
- Empty mask: mask=0 -> seq_done at T+1, last_cycles=1, no start pulses.
- Stray and early done:
  - data_done pulsed in IDLE -> no effect;
  - data_done pulsed with data_start -> ignored, so the sequence waits for the next data_done;
  - post_done pulsed during WICP -> ignored.
- Prefetch (CFG_PREFETCH_EN): second bundle offered at T+2 is accepted; cfg_busy=1 until DONE; first stage of the second bundle starts in the cycle after the first seq_done, with no IDLE cycle; data_cfg switches on that same edge.

Source files
------------

// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg: shared FSM states, stage indices and next-enabled-stage lookup for pe_cfg_sequencer
package pe_seq_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, DATA = 3'd1, WICP = 3'd2, TMPC = 3'd3, POST = 3'd4, DONE = 3'd5} state_t;
  localparam int STG_DATA = 0;
  localparam int STG_WICP = 1;
  localparam int STG_TMPC = 2;
  localparam int STG_POST = 3;
  // lowest enabled stage with index >= from, or DONE when none is left
  function automatic state_t next_stage(input logic [2:0] from, input logic [3:0] mask);
    next_stage = DONE;
    for (int i = 3; i >= 0; i--)
      if (i >= int'(from) && mask[i]) next_stage = state_t'(3'(i + 1));
  endfunction
endpackage

// File: rtl/pe_cfg_slot.sv
// pe_cfg_slot: one-entry pending buffer for a config bundle
module pe_cfg_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_d,
  output logic         o_full
);
  logic         r_full;
  logic [W-1:0] r_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_d    <= '0;
    end else if (i_push) begin
      r_full <= 1'b1;
      r_d    <= i_d;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end
  assign o_d    = r_d;
  assign o_full = r_full;
endmodule

// File: rtl/pe_cfg_sequencer.sv
// pe_cfg_sequencer: runs enabled PE stages DATA->WICP->TMPC->POST per config bundle.
// CFG_PREFETCH_EN adds a one-entry bundle buffer so the next run starts straight after DONE.
module pe_cfg_sequencer
  import pe_seq_pkg::*;
#(
  parameter int DATA_CWIDTH = 32,
  parameter int WICP_CWIDTH = 32,
  parameter int TMPC_CWIDTH = 32,
  parameter int POST_CWIDTH = 32,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_busy,
  input  logic [3:0]             cfg_mask,
  input  logic [DATA_CWIDTH-1:0] cfg_data_data,
  input  logic [WICP_CWIDTH-1:0] cfg_wicp_data,
  input  logic [TMPC_CWIDTH-1:0] cfg_tmpc_data,
  input  logic [POST_CWIDTH-1:0] cfg_post_data,
  output logic                   data_start,
  output logic                   wicp_start,
  output logic                   tmpc_start,
  output logic                   post_start,
  output logic [DATA_CWIDTH-1:0] data_cfg,
  output logic [WICP_CWIDTH-1:0] wicp_cfg,
  output logic [TMPC_CWIDTH-1:0] tmpc_cfg,
  output logic [POST_CWIDTH-1:0] post_cfg,
  input  logic                   data_done,
  input  logic                   wicp_done,
  input  logic                   tmpc_done,
  input  logic                   post_done,
  output logic                   seq_done,
  output logic [CNT_WIDTH-1:0]   last_cycles
);
  localparam int BW = 4 + DATA_CWIDTH + WICP_CWIDTH + TMPC_CWIDTH + POST_CWIDTH;
  state_t                 r_state, w_nxt;
  logic [3:0]             r_start, r_mask, w_done, w_start_nxt;
  logic                   r_seq_done, w_acc, w_launch, w_in_stage, w_done_act;
  logic [1:0]             w_idx;
  logic [CNT_WIDTH-1:0]   r_cnt, r_last, w_cnt_nxt;
  logic [DATA_CWIDTH-1:0] r_data_cfg;
  logic [WICP_CWIDTH-1:0] r_wicp_cfg;
  logic [TMPC_CWIDTH-1:0] r_tmpc_cfg;
  logic [POST_CWIDTH-1:0] r_post_cfg;
  logic [BW-1:0]          w_in, w_src;
  assign w_in   = {cfg_mask, cfg_post_data, cfg_tmpc_data, cfg_wicp_data, cfg_data_data};
  assign w_done = {post_done, tmpc_done, wicp_done, data_done};
  assign w_acc  = cfg_valid && !cfg_busy;
`ifdef CFG_PREFETCH_EN
  logic          w_full, w_hold;
  logic [BW-1:0] w_buf;
  assign w_hold   = r_state == IDLE || r_state == DONE;
  assign w_launch = w_hold && (w_full || w_acc);
  assign w_src    = w_full ? w_buf : w_in;
  assign cfg_busy = w_full;
  pe_cfg_slot #(.W(BW)) u_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_acc && !w_hold),
    .i_pop  (r_state == DONE && w_full),
    .i_d    (w_in),
    .o_d    (w_buf),
    .o_full (w_full)
  );
`else
  logic r_busy;
  assign w_launch = w_acc;
  assign w_src    = w_in;
  assign cfg_busy = r_busy;
  always_ff @(posedge clk) begin
    if (!rst_n) r_busy <= 1'b0;
    else r_busy <= w_nxt != IDLE;
  end
`endif
  always_comb begin
    w_idx      = 2'(3'(r_state) - 3'd1);
    w_in_stage = r_state inside {DATA, WICP, TMPC, POST};
    // a done coinciding with its own start pulse belongs to no live request
    w_done_act = w_in_stage && w_done[w_idx] && !r_start[w_idx];
    w_nxt      = w_launch ? next_stage(3'd0, w_src[BW-1 -: 4]) :
                 w_done_act ? next_stage(3'(w_idx) + 3'd1, r_mask) :
                 r_state == DONE ? IDLE : r_state;
    w_cnt_nxt  = w_launch ? CNT_WIDTH'(1) : r_cnt + CNT_WIDTH'(1);
    for (int i = 0; i < 4; i++)
      w_start_nxt[i] = 3'(w_nxt) == 3'(i + 1) && w_nxt != r_state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_start    <= '0;
      r_seq_done <= 1'b0;
      r_mask     <= '0;
      r_cnt      <= '0;
      r_last     <= '0;
      r_data_cfg <= '0;
      r_wicp_cfg <= '0;
      r_tmpc_cfg <= '0;
      r_post_cfg <= '0;
    end else begin
      r_state    <= w_nxt;
      r_start    <= w_start_nxt;
      r_seq_done <= w_nxt == DONE;
      r_cnt      <= w_cnt_nxt;
      if (w_nxt == DONE) r_last <= w_cnt_nxt;
      if (w_launch) {r_mask, r_post_cfg, r_tmpc_cfg, r_wicp_cfg, r_data_cfg} <= w_src;
    end
  end
  assign data_start  = r_start[STG_DATA];
  assign wicp_start  = r_start[STG_WICP];
  assign tmpc_start  = r_start[STG_TMPC];
  assign post_start  = r_start[STG_POST];
  assign data_cfg    = r_data_cfg;
  assign wicp_cfg    = r_wicp_cfg;
  assign tmpc_cfg    = r_tmpc_cfg;
  assign post_cfg    = r_post_cfg;
  assign seq_done    = r_seq_done;
  assign last_cycles = r_last;
endmodule

// File: tb/tb_pe_cfg_sequencer.sv
// tb_pe_cfg_sequencer: table vectors, hand sequences and randomized runs against a timeline model
module tb_pe_cfg_sequencer;
  localparam int CW = 4;
  logic clk = 0, rst_n = 0, cfg_valid = 0, cfg_busy;
  logic [3:0] cfg_mask = 0;
  logic [31:0] cfg_data_data = 0, cfg_wicp_data = 0, cfg_tmpc_data = 0, cfg_post_data = 0;
  logic data_start, wicp_start, tmpc_start, post_start, seq_done;
  logic [31:0] data_cfg, wicp_cfg, tmpc_cfg, post_cfg;
  logic data_done = 0, wicp_done = 0, tmpc_done = 0, post_done = 0;
  logic [CW-1:0] last_cycles;
  int n_chk = 0, n_fail = 0;

  pe_cfg_sequencer #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_busy(cfg_busy), .cfg_mask(cfg_mask),
    .cfg_data_data(cfg_data_data), .cfg_wicp_data(cfg_wicp_data),
    .cfg_tmpc_data(cfg_tmpc_data), .cfg_post_data(cfg_post_data),
    .data_start(data_start), .wicp_start(wicp_start), .tmpc_start(tmpc_start), .post_start(post_start),
    .data_cfg(data_cfg), .wicp_cfg(wicp_cfg), .tmpc_cfg(tmpc_cfg), .post_cfg(post_cfg),
    .data_done(data_done), .wicp_done(wicp_done), .tmpc_done(tmpc_done), .post_done(post_done),
    .seq_done(seq_done), .last_cycles(last_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      m;
    logic [3:0][7:0] dur;
    logic [3:0]      xtra;
    int              xk;
    logic [3:0][7:0] es;
    int              ed;
    int              el;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] starts();
    return {post_start, tmpc_start, wicp_start, data_start};
  endfunction

  // dur = cycles from a stage's start through its done inclusive; xtra pulses extra dones at cycle xk
  task automatic run(input string tag, input logic [3:0] m, input logic [3:0][7:0] dur,
                     input logic [3:0] xtra, input int xk,
                     input logic [3:0][7:0] es, input int ed, input int el);
    logic [31:0] w[4];
    int due[4], first[4], cnt[4];
    int done_k = 0;
    logic [CW-1:0] last = 0;
    logic [3:0] dn, st;
    logic [127:0] cfg_at_done = 0;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom(); due[i] = -1; first[i] = 0; cnt[i] = 0;
    end
    @(negedge clk);
    cfg_valid = 1; cfg_mask = m;
    cfg_data_data = w[0]; cfg_wicp_data = w[1]; cfg_tmpc_data = w[2]; cfg_post_data = w[3];
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cfg_valid = 0;
        cfg_data_data = ~w[0]; cfg_wicp_data = ~w[1]; cfg_tmpc_data = ~w[2]; cfg_post_data = ~w[3];
        chk({tag, " busy@T+1"}, 64'(cfg_busy), 64'd1);
      end
      st = starts();
      for (int i = 0; i < 4; i++)
        if (st[i]) begin
          cnt[i]++;
          if (first[i] == 0) first[i] = k;
          due[i] = k + int'(dur[i]) - 1;
        end
      if (seq_done && done_k == 0) begin
        done_k = k; last = last_cycles;
        cfg_at_done = {post_cfg, tmpc_cfg, wicp_cfg, data_cfg};
      end
      for (int i = 0; i < 4; i++) dn[i] = (due[i] == k) || (k == xk && xtra[i]);
      {post_done, tmpc_done, wicp_done, data_done} = dn;
      if (done_k != 0 && k == done_k + 1) begin
        chk({tag, " busy after done"}, 64'(cfg_busy), 64'd0);
        break;
      end
    end
    {post_done, tmpc_done, wicp_done, data_done} = 4'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s start_cycle[%0d]", tag, i), 64'(first[i]), 64'(es[i]));
      chk($sformatf("%s start_pulses[%0d]", tag, i), 64'(cnt[i]), 64'(es[i] != 0));
    end
    chk({tag, " seq_done cycle"}, 64'(done_k), 64'(ed));
    chk({tag, " last_cycles"}, 64'(last), 64'(el));
    chk({tag, " cfg words held"}, cfg_at_done[63:0], {w[1], w[0]});
    chk({tag, " cfg words held hi"}, cfg_at_done[127:64], {w[3], w[2]});
  endtask

  initial begin
    logic [3:0][7:0] d, es;
    int t;
    logic [3:0] seen;
    tbl[0] = '{4'hf, {8'd3, 8'd3, 8'd3, 8'd3}, 4'h0, 0, {8'd10, 8'd7, 8'd4, 8'd1}, 13, 13};
    tbl[1] = '{4'ha, {8'd2, 8'd2, 8'd2, 8'd2}, 4'h0, 0, {8'd3, 8'd0, 8'd1, 8'd0}, 5, 5};
    tbl[2] = '{4'h0, {8'd2, 8'd2, 8'd2, 8'd2}, 4'h0, 0, {8'd0, 8'd0, 8'd0, 8'd0}, 1, 1};
    tbl[3] = '{4'h1, {8'd3, 8'd3, 8'd3, 8'd3}, 4'h1, 1, {8'd0, 8'd0, 8'd0, 8'd1}, 4, 4};
    tbl[4] = '{4'hf, {8'd3, 8'd3, 8'd3, 8'd3}, 4'h8, 5, {8'd10, 8'd7, 8'd4, 8'd1}, 13, 13};
    tbl[5] = '{4'h4, {8'd5, 8'd5, 8'd5, 8'd5}, 4'h0, 0, {8'd0, 8'd1, 8'd0, 8'd0}, 6, 6};
    tbl[6] = '{4'hf, {8'd6, 8'd6, 8'd6, 8'd6}, 4'h0, 0, {8'd19, 8'd13, 8'd7, 8'd1}, 25, 9};

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(cfg_busy), 64'd0);
    chk("reset starts", 64'(starts()), 64'd0);
    chk("reset seq_done", 64'(seq_done), 64'd0);
    chk("reset cfgs", {data_cfg | wicp_cfg, tmpc_cfg | post_cfg}, 64'd0);
    chk("reset last_cycles", 64'(last_cycles), 64'd0);
    rst_n = 1;

    data_done = 1;
    @(negedge clk);
    data_done = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen |= starts() | {2'b0, seq_done, cfg_busy};
    end
    chk("stray done in IDLE", 64'(seen), 64'd0);

    for (int v = 0; v < 7; v++)
      run($sformatf("vec%0d", v), tbl[v].m, tbl[v].dur, tbl[v].xtra, tbl[v].xk, tbl[v].es, tbl[v].ed, tbl[v].el);

    @(negedge clk);
    cfg_valid = 1; cfg_mask = 4'hf; cfg_data_data = 32'h1234_5678;
    @(negedge clk);
    cfg_valid = 0;
    @(negedge clk);
    @(negedge clk);
    data_done = 1;
    @(negedge clk);
    data_done = 0;
    chk("midrun wicp_start", 64'(wicp_start), 64'd1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrun reset busy", 64'(cfg_busy), 64'd0);
    chk("midrun reset data_cfg", 64'(data_cfg), 64'd0);
    chk("midrun reset last", 64'(last_cycles), 64'd0);
    wicp_done = 1;
    seen = starts() | {2'b0, seq_done, 1'b0};
    @(negedge clk);
    wicp_done = 0;
    repeat (6) begin
      seen |= starts() | {2'b0, seq_done, cfg_busy};
      @(negedge clk);
    end
    chk("midrun reset quiet", 64'(seen), 64'd0);

    for (int r = 0; r < 20; r++) begin
      logic [3:0] m;
      m = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(2, 6));
      es = '0;
      t = 1;
      for (int i = 0; i < 4; i++)
        if (m[i]) begin
          es[i] = 8'(t);
          t += int'(d[i]);
        end
      run($sformatf("rnd%0d", r), m, d, 4'h0, 0, es, t, t % (1 << CW));
    end

`ifdef CFG_PREFETCH_EN
    @(negedge clk);
    cfg_valid = 1; cfg_mask = 4'h3; cfg_data_data = 32'hAAAA_0001;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      cfg_valid = (k == 2);
      if (k == 2) begin
        cfg_mask = 4'h1; cfg_data_data = 32'hBBBB_0002;
      end
      if (k == 3) begin
        chk("pf busy after 2nd accept", 64'(cfg_busy), 64'd1);
        chk("pf data_cfg unchanged", 64'(data_cfg), 64'hAAAA_0001);
      end
      if (k == 7) chk("pf first seq_done", 64'(seq_done), 64'd1);
      if (k == 8) begin
        chk("pf back-to-back start", 64'(data_start), 64'd1);
        chk("pf data_cfg switched", 64'(data_cfg), 64'hBBBB_0002);
        chk("pf busy cleared", 64'(cfg_busy), 64'd0);
      end
      if (k == 11) begin
        chk("pf second seq_done", 64'(seq_done), 64'd1);
        chk("pf second last", 64'(last_cycles), 64'd4);
      end
      data_done = (k == 3 || k == 10);
      wicp_done = (k == 6);
    end
    data_done = 0; wicp_done = 0;
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
